// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if -- bundle of every handshake/bus signal around alu_arbiter.
//
// Parameter:
//   DATA_WIDTH  operand/result width, must equal the arbiter's DATA_WIDTH.
//
// Signal groups:
//   req0_* / req1_*  requester channels (valid/ready, 2-bit op, operands a/b)
//   resp_*           response channel (valid/ready, id, result, overflow, error)
//   alu_*            serial command to the ALU and its completion report
//
// Modports:
//   slave   arbiter view
//   master  environment view (requesters, response sink, ALU)
interface alu_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  req0_valid;
   logic                  req0_ready;
   logic [1:0]            req0_op;
   logic [DATA_WIDTH-1:0] req0_a;
   logic [DATA_WIDTH-1:0] req0_b;

   logic                  req1_valid;
   logic                  req1_ready;
   logic [1:0]            req1_op;
   logic [DATA_WIDTH-1:0] req1_a;
   logic [DATA_WIDTH-1:0] req1_b;

   logic                  resp_valid;
   logic                  resp_ready;
   logic                  resp_id;
   logic [DATA_WIDTH-1:0] resp_result;
   logic                  resp_overflow;
   logic                  resp_error;

   logic                  alu_opcode_valid;
   logic                  alu_opcode;
   logic [DATA_WIDTH-1:0] alu_data;
   logic                  alu_done;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_overflow;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  resp_ready, alu_done, alu_result, alu_overflow,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_result, resp_overflow, resp_error,
      output alu_opcode_valid, alu_opcode, alu_data
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output resp_ready, alu_done, alu_result, alu_overflow,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_result, resp_overflow, resp_error,
      input  alu_opcode_valid, alu_opcode, alu_data
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter -- round-robin arbiter sharing one serial-command ALU between two
// requesters. A granted request is captured, sent to the ALU as three beats
// (start, A with op[0], B with op[1]), and the ALU's answer is returned on the
// response channel tagged with the requester index.
//
// Parameters:
//   DATA_WIDTH      operand/result width (must match the ALU and the interface)
//   TIMEOUT_CYCLES  watchdog limit in WAIT_DONE cycles (timeout build only)
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      alu_arbiter_if.slave: requester, response and ALU signals
//
// Build option:
//   ALU_ARB_TIMEOUT_EN  when defined, a watchdog ends WAIT_DONE after
//                       TIMEOUT_CYCLES cycles without alu_done and answers with
//                       resp_error=1. When undefined, WAIT_DONE waits forever
//                       and resp_error is tied low.
module alu_arbiter #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic         clk,
   input logic         reset_n,
   alu_arbiter_if.slave bus
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("alu_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   localparam logic [2:0] IDLE        = 3'd0;
   localparam logic [2:0] ISSUE_START = 3'd1;
   localparam logic [2:0] ISSUE_A     = 3'd2;
   localparam logic [2:0] ISSUE_B     = 3'd3;
   localparam logic [2:0] WAIT_DONE   = 3'd4;
   localparam logic [2:0] RESP        = 3'd5;

   logic [2:0]            state_q, state_d;
   // Index of the requester granted last; reset to 1 so req0 wins a tie first.
   logic                  last_q, last_d;
   logic                  id_q, id_d;
   logic [1:0]            op_q, op_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  ovf_q, ovf_d;

   logic any_req;
   logic grant_id;

   assign any_req  = bus.req0_valid | bus.req1_valid;
   // Tie goes to the requester not granted last; otherwise the lone requester.
   assign grant_id = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;

`ifdef ALU_ARB_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
`endif

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      id_d     = id_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      ovf_d    = ovf_q;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = ISSUE_START;
               last_d  = grant_id;
               id_d    = grant_id;
               op_d    = grant_id ? bus.req1_op : bus.req0_op;
               a_d     = grant_id ? bus.req1_a  : bus.req0_a;
               b_d     = grant_id ? bus.req1_b  : bus.req0_b;
            end
         end
         ISSUE_START: state_d = ISSUE_A;
         ISSUE_A:     state_d = ISSUE_B;
         ISSUE_B: begin
            state_d = WAIT_DONE;
`ifdef ALU_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT_DONE: begin
            // alu_done is only honoured here; in the expiry cycle it still wins.
            if (bus.alu_done) begin
               state_d  = RESP;
               result_d = bus.alu_result;
               ovf_d    = bus.alu_overflow;
`ifdef ALU_ARB_TIMEOUT_EN
               err_d    = 1'b0;
            end else if (cnt_q == CntMax) begin
               state_d  = RESP;
               result_d = '0;
               ovf_d    = 1'b0;
               err_d    = 1'b1;
            end else begin
               cnt_d    = cnt_q + CntW'(1);
`endif
            end
         end
         RESP: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         id_q     <= 1'b0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         id_q     <= id_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef ALU_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`endif

   // Outputs. req_ready is gated by reset_n so every output drops as soon as
   // reset is asserted, even with a request still pending.
   logic in_idle;
   logic in_resp;

   assign in_idle = (state_q == IDLE) & reset_n;
   assign in_resp = (state_q == RESP);

   assign bus.req0_ready = in_idle & any_req & ~grant_id;
   assign bus.req1_ready = in_idle & any_req &  grant_id;

   always_comb begin
      bus.alu_opcode_valid = 1'b0;
      bus.alu_opcode       = 1'b0;
      bus.alu_data         = '0;
      case (state_q)
         ISSUE_START: bus.alu_opcode_valid = 1'b1;
         ISSUE_A: begin
            bus.alu_opcode_valid = 1'b1;
            bus.alu_opcode       = op_q[0];
            bus.alu_data         = a_q;
         end
         ISSUE_B: begin
            bus.alu_opcode_valid = 1'b1;
            bus.alu_opcode       = op_q[1];
            bus.alu_data         = b_q;
         end
         default: ;
      endcase
   end

   assign bus.resp_valid    = in_resp;
   assign bus.resp_id       = in_resp & id_q;
   assign bus.resp_result   = in_resp ? result_q : '0;
   assign bus.resp_overflow = in_resp & ovf_q;
`ifdef ALU_ARB_TIMEOUT_EN
   assign bus.resp_error    = in_resp & err_q;
`else
   assign bus.resp_error    = 1'b0;
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 8, operand/result width; SHALL match attached simple ALU.
REQ-002 Parameter TIMEOUT_CYCLES, 16, watchdog limit in cycles (used only per REQ-027).
REQ-003 Ports SHALL be: clk  in  1  single clock, all logic rising-edge; reset_n  in  1  asynchronous, active-low reset.
REQ-004 req0_valid/req1_valid  in  1  requester i has an operation pending.
REQ-005 req0_ready/req1_ready  out  1  request i accepted this cycle.
REQ-006 req0_op/req1_op  in  2  opcode: 00 ADD, 01 SUB, 10 PAR, 11 COMP.
REQ-007 req0_a/req1_a, req0_b/req1_b  in  DATA_WIDTH  operands A and B.
REQ-008 resp_valid  out  1; resp_ready  in  1; resp_id  out  1 (requester index); resp_result  out  DATA_WIDTH; resp_overflow  out  1; resp_error  out  1.
REQ-009 alu_opcode_valid  out  1; alu_opcode  out  1; alu_data  out  DATA_WIDTH  serial command to ALU.
REQ-010 alu_done  in  1; alu_result  in  DATA_WIDTH; alu_overflow  in  1  ALU completion.

Function
REQ-011 FSM states SHALL be IDLE, ISSUE_START, ISSUE_A, ISSUE_B, WAIT_DONE, RESP.
REQ-012 IDLE: if any req_valid, grant one, assert its req_ready combinationally that cycle, capture id/op/A/B, go ISSUE_START; else stay.
REQ-013 Arbitration SHALL be round-robin: single requester always granted; both valid -> grant the one not granted last; after reset req0 has priority.
REQ-014 At most one req_ready SHALL be high per cycle; req_ready only in IDLE.
REQ-015 Requester SHALL hold op/A/B stable while valid && !ready; the block captures only on valid && ready.
REQ-016 ISSUE_START: alu_opcode_valid=1, alu_opcode=0, alu_data=0.
REQ-017 ISSUE_A: alu_opcode_valid=1, alu_opcode=op[0], alu_data=A.
REQ-018 ISSUE_B: alu_opcode_valid=1, alu_opcode=op[1], alu_data=B; next WAIT_DONE.
REQ-019 Outside ISSUE_* states alu_opcode_valid, alu_opcode, alu_data SHALL be 0.
REQ-020 WAIT_DONE: on alu_done=1 capture alu_result/alu_overflow, go RESP; alu_done in any other state SHALL be ignored.
REQ-021 RESP: resp_valid=1 with registered id/result/overflow/error stable until resp_ready=1; on resp_valid && resp_ready go IDLE.
REQ-022 Request arriving during a transaction SHALL wait (ready=0) and be considered in the next IDLE cycle; no request is dropped.
REQ-023 Latency: accept at cycle T -> alu_opcode_valid high T+1..T+3; resp_valid rises the cycle after alu_done seen.
REQ-024 resp_error SHALL be 0 except per REQ-027; resp_* outputs SHALL be 0 when resp_valid=0.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, all outputs 0, captured registers 0, round-robin pointer to favour req0.
REQ-026 Reset mid-transaction SHALL abort it with no response; first post-reset cycle behaves as IDLE.

Configuration
REQ-027 With ALU_ARB_TIMEOUT_EN defined: counter cleared on WAIT_DONE entry; if alu_done absent for TIMEOUT_CYCLES cycles, go RESP with resp_error=1, resp_result=0, resp_overflow=0; alu_done in the same cycle as expiry wins (no error).
REQ-028 Without ALU_ARB_TIMEOUT_EN: no counter; WAIT_DONE waits indefinitely; resp_error tied 0.

Verification
REQ-029 req0 ADD A=8'h05 B=8'h03 alone -> req0_ready at T, opcode_valid T+1..T+3 with opcode 0,0,0 data 0,05,03; resp id=0 result=08 overflow=0.
REQ-030 req0 and req1 valid same cycle after reset -> req0 served first, req1 next; repeat both -> order alternates 1,0.
REQ-031 req1 ADD A=8'hFF B=8'h01 -> resp id=1 result=00 overflow=1 (as reported by ALU).
REQ-032 resp_ready held 0 for 5 cycles -> resp_valid and payload stable, no new req_ready until handshake.
REQ-033 reset_n low during ISSUE_A -> all outputs 0 immediately; pending request re-accepted after release, single response.
REQ-034 ALU_ARB_TIMEOUT_EN, ALU never asserts done -> resp_error=1 after 16 WAIT_DONE cycles, result=0; without macro, no response.
